// File: rtl/mem_pkg.sv
// Shared widths, controller state encoding and the word address legality check
// for the word-to-byte memory controller.
package mem_pkg;

    localparam int ADDR_W = 20;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } ctrl_state_t;

    // A word is legal when it is 4-byte aligned and its last byte lies below limit.
    // The sum is taken one bit wider so addresses near the top cannot wrap.
    function automatic logic word_addr_ok(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] limit);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, addr} + (ADDR_W + 1)'(3);
        return (addr[1:0] == 2'b00) && (last_byte < {1'b0, limit});
    endfunction

endpackage

// File: rtl/byte_lane_sequencer.sv
// Byte lane bookkeeping shared by reads and writes: a 2-bit issue counter, the
// byte selected from the outgoing word, and a byte inserted into the read staging word.
module byte_lane_sequencer
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [WORD_W-1:0] word_in,
    input  logic [WORD_W-1:0] stage_in,
    input  logic [1:0]        ins_idx,
    input  logic [BYTE_W-1:0] ins_byte,
    output logic [1:0]        cnt,
    output logic [BYTE_W-1:0] sel_byte,
    output logic [WORD_W-1:0] stage_out
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Little-endian: lane k is bits [8k+7:8k].
    always_comb begin
        sel_byte  = word_in[{cnt_q, 3'b000} +: BYTE_W];
        stage_out = stage_in;
        stage_out[{ins_idx, 3'b000} +: BYTE_W] = ins_byte;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/word_mem_controller.sv
// Splits one 32-bit word request into four byte accesses on a byte-wide RAM,
// rejecting misaligned or out-of-range words before any RAM access.
module word_mem_controller
    import mem_pkg::*;
#(
    parameter logic [19:0] ADDR_LIMIT = 20'hA0000,
    parameter int          RD_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic [19:0] ram_address_20bits,
    output logic [7:0]  ram_data_8bits,
    output logic        ram_write_enable,
    input  logic [7:0]  ram_q_8bits
);

    ctrl_state_t state_q, state_d;

    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [BYTE_W-1:0]     ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  issue_q, issue_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [1:0]            cap_q, cap_d;
    logic [WORD_W-1:0]     stage_q, stage_d;

    logic                  step;
    logic [1:0]            lane_cnt;
    logic [BYTE_W-1:0]     lane_byte;
    logic [WORD_W-1:0]     stage_ins;
    logic [WORD_W-1:0]     lane_word;
    logic                  capture;

    // Byte 0 is issued on the accepting edge, before the request is latched.
    assign lane_word = (state_q == IDLE) ? req_wdata : wdata_q;

    byte_lane_sequencer u_lanes (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .word_in   (lane_word),
        .stage_in  (stage_q),
        .ins_idx   (cap_q),
        .ins_byte  (ram_q_8bits),
        .cnt       (lane_cnt),
        .sel_byte  (lane_byte),
        .stage_out (stage_ins)
    );

    // One valid bit per issued read address, delayed to the cycle its byte is on ram_q.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    assign capture = vld_q[RD_LATENCY-1];

    // Handshake: req is looked at only in IDLE; once taken, busy stays high until
    // the done pulse, and a req seen in any other state is dropped, not queued.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        issue_d    = 1'b0;
        cap_d      = cap_q;
        stage_d    = stage_q;
        step       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (!word_addr_ok(req_addr, ADDR_LIMIT)) begin
                        state_d = ERR;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        busy_d     = 1'b1;
                        step       = 1'b1;
                        ram_addr_d = req_addr;
                        if (req_we) begin
                            state_d    = WRITE;
                            ram_we_d   = 1'b1;
                            ram_data_d = lane_byte;
                        end else begin
                            state_d = READ;
                            issue_d = 1'b1;
                            cap_d   = 2'd0;
                            stage_d = '0;
                        end
                    end
                end
            end

            // The lane counter wraps to 0 once byte 3 is out, marking issue complete.
            WRITE: begin
                if (lane_cnt != 2'd0) begin
                    step       = 1'b1;
                    ram_addr_d = addr_q + ADDR_W'(lane_cnt);
                    ram_data_d = lane_byte;
                    ram_we_d   = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            READ: begin
                if (lane_cnt != 2'd0) begin
                    step       = 1'b1;
                    ram_addr_d = addr_q + ADDR_W'(lane_cnt);
                    issue_d    = 1'b1;
                end
                if (capture) begin
                    stage_d = stage_ins;
                    cap_d   = cap_q + 2'd1;
                    if (cap_q == 2'd3) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        rdata_d = stage_ins;
                    end
                end
            end

            DONE: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            issue_q    <= 1'b0;
            vld_q      <= '0;
            cap_q      <= 2'd0;
            stage_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            issue_q    <= issue_d;
            vld_q      <= vld_d;
            cap_q      <= cap_d;
            stage_q    <= stage_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign rdata              = rdata_q;
    assign ram_address_20bits = ram_addr_q;
    assign ram_data_8bits     = ram_data_q;
    assign ram_write_enable   = ram_we_q;

endmodule

// File: tb/tb_word_mem_controller.sv
// Directed bench for word_mem_controller driving a byte-wide RAM model with
// one cycle of read latency.
module tb_word_mem_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] rdata;
    logic [19:0] ram_address_20bits;
    logic [7:0]  ram_data_8bits;
    logic        ram_write_enable;
    logic [7:0]  ram_q_8bits;

    logic        mem_clr;
    logic [7:0]  mem [0:1048575];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_rdata;

    always #50 clk = ~clk;

    word_mem_controller #(
        .ADDR_LIMIT (20'hA0000),
        .RD_LATENCY (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .rdata              (rdata),
        .ram_address_20bits (ram_address_20bits),
        .ram_data_8bits     (ram_data_8bits),
        .ram_write_enable   (ram_write_enable),
        .ram_q_8bits        (ram_q_8bits)
    );

    // RAM model: synchronous write, registered read, read-before-write.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1048576; i++) mem[i] <= 8'h00;
            ram_q_8bits <= 8'h00;
        end else begin
            if (ram_write_enable) mem[ram_address_20bits] <= ram_data_8bits;
            ram_q_8bits <= mem[ram_address_20bits];
        end
    end

    always @(posedge clk) begin
        if (ram_write_enable) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return {mem[a + 20'd3], mem[a + 20'd2], mem[a + 20'd1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request, counts cycles after the accepting edge until done,
    // and checks the done cycle, error flag and busy around the operation.
    task automatic run_op(input string tag, input logic we, input logic [19:0] a,
                          input logic [31:0] wd, input int exp_cyc, input logic exp_err);
        int   n;
        logic seen;
        logic err_at_done;
        n = 0;
        seen = 1'b0;
        err_at_done = 1'b0;
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(posedge clk);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req = 1'b0;
                check({tag, " busy_first"}, 32'(busy), exp_err ? 32'd0 : 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                err_at_done = error;
                last_rdata = rdata;
            end
        end
        check({tag, " done_cycle"}, 32'(n), 32'(exp_cyc));
        check({tag, " error"}, 32'(err_at_done), 32'(exp_err));
        @(negedge clk);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wc0;
        int dc0;
        int n;
        int first_done;
        int second_done;

        rst = 1'b1; mem_clr = 1'b1;
        req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        @(posedge clk);
        @(negedge clk) mem_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst busy",  32'(busy), 32'd0);
        check("rst done",  32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst ram_addr", 32'(ram_address_20bits), 32'd0);
        check("rst ram_data", 32'(ram_data_8bits), 32'd0);
        check("rst ram_we", 32'(ram_write_enable), 32'd0);
        rst = 1'b0;

        // Basic little-endian write and read back.
        run_op("wr0", 1'b1, 20'h00000, 32'hA1B2C3D4, 5, 1'b0);
        check("wr0 b0", 32'(mem[20'h00000]), 32'h000000D4);
        check("wr0 b3", 32'(mem[20'h00003]), 32'h000000A1);
        check("wr0 word", mem_word(20'h00000), 32'hA1B2C3D4);
        run_op("rd0", 1'b0, 20'h00000, 32'h0, 6, 1'b0);
        check("rd0 rdata", last_rdata, 32'hA1B2C3D4);

        // Last legal word.
        run_op("wr_top", 1'b1, 20'h9FFFC, 32'hDEADBEEF, 5, 1'b0);
        check("wr_top word", mem_word(20'h9FFFC), 32'hDEADBEEF);
        run_op("rd_top", 1'b0, 20'h9FFFC, 32'h0, 6, 1'b0);
        check("rd_top rdata", last_rdata, 32'hDEADBEEF);

        // Rejected requests: no RAM writes, rdata untouched.
        wc0 = we_cnt;
        run_op("mis", 1'b1, 20'h9FFFE, 32'h12345678, 1, 1'b1);
        run_op("range", 1'b1, 20'hA0000, 32'h12345678, 1, 1'b1);
        run_op("range_hi", 1'b0, 20'hFFFFC, 32'h0, 1, 1'b1);
        check("err no_we", 32'(we_cnt - wc0), 32'd0);
        check("err rdata_held", rdata, 32'hDEADBEEF);

        // Reset sampled on the edge after acceptance: only byte 0 reaches the RAM.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 20'h00010; req_wdata = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        dc0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ram_we", 32'(ram_write_enable), 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort no_done", 32'(done_cnt - dc0), 32'd0);
        check("abort mem", mem_word(20'h00010), 32'h00000044);
        run_op("rd_abort", 1'b0, 20'h00010, 32'h0, 6, 1'b0);
        check("rd_abort rdata", last_rdata, 32'h00000044);

        // A request changed and held while busy is ignored, then taken in IDLE.
        first_done = 0;
        second_done = 0;
        n = 0;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 20'h00020; req_wdata = 32'h55667788;
        @(posedge clk);
        while (second_done == 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_addr = 20'h00040;
                req_wdata = 32'hCAFEF00D;
            end
            if (n == 7) req = 1'b0;
            if (done) begin
                if (first_done == 0) first_done = n;
                else second_done = n;
            end
        end
        req = 1'b0;
        check("hold first_done", 32'(first_done), 32'd5);
        check("hold second_done", 32'(second_done), 32'd11);
        check("hold word0", mem_word(20'h00020), 32'h55667788);
        check("hold word1", mem_word(20'h00040), 32'hCAFEF00D);
        run_op("rd_hold", 1'b0, 20'h00040, 32'h0, 6, 1'b0);
        check("rd_hold rdata", last_rdata, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
